uart_rx_fifo: RTL and testbench

UART receiver with a 16-entry receive FIFO for the picorv32 SoC; the receive counterpart of the existing transmitter path. It synchronizes the `rxd` pad, frames 8N1 characters and queues received bytes for the CPU-side bus interface in `top`. It runs on the SoC clock (CLK_OUT2, 50 MHz), and the board-level `rxd` tie-off is replaced by this block.

---
 rtl/uart_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a power-of-two receive FIFO.
// The rxd pad is synchronized and framed by a mid-bit sampling FSM.
// Good characters are queued, and framing/overrun events latch sticky flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxd,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [FIFO_DEPTH_LOG2:0] rx_count,
  output logic                     frame_err,
  output logic                     overrun,
  input  logic                     clear_err
);

  localparam int HALF  = CLKS_PER_BIT >> 1;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic          sync1, sync2, sync_d;
  logic          fall;
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic stop_tick, push_req, frame_set;
  logic pop, full, push, ovr_set;

  assign fall = sync_d & ~sync2;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= rxd;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // Character framing: half-bit start check, then one sample per bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            timer <= HALF_RELOAD;
            state <= START;
          end
        end
        START: begin
          if (timer == '0) begin
            if (sync2) begin
              state <= IDLE;
            end else begin
              timer   <= BIT_RELOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          if (timer == '0) begin
            shreg <= {sync2, shreg[7:1]};
            timer <= BIT_RELOAD;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP: begin
          if (timer == '0) state <= sync2 ? IDLE : WAIT_HIGH;
          else timer <= timer - TW'(1);
        end
        WAIT_HIGH: begin
          if (sync2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The stop-sample cycle decides push or framing error directly, so the byte
  // lands in the FIFO on the same edge as the stop sample.
  assign stop_tick = (state == STOP) && (timer == '0);
  assign push_req  = stop_tick && sync2;
  assign frame_set = stop_tick && !sync2;

  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (count == FULL_COUNT);
  assign push     = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;

  // FIFO storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)      frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (ovr_set)        overrun   <= 1'b1;
      else if (clear_err) overrun   <= 1'b0;
    end
  end

  assign rx_data  = mem[rd_ptr];
  assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: serial frames are driven on rxd and the FIFO
// output is compared against a queue-based model of received characters.
module tb_uart_rx_fifo;
  localparam int CPB = 16;
  localparam int L2  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [L2:0] rx_count;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(L2)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_count(rx_count), .frame_err(frame_err),
    .overrun(overrun), .clear_err(clear_err)
  );

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = stop_bit;
    wait_cycles(CPB);
    rxd = 1'b1;
  endtask

  task automatic do_pop(output logic [7:0] d);
    d = rx_data;
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    wait_cycles(1);
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", rx_valid); end
    checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", rx_count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_single_byte();
    int lat;
    logic [7:0] d;
    lat = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int n = 1; n <= 300; n++) begin
          @(posedge clk); #1;
          if (rx_valid === 1'b1) begin lat = n; break; end
        end
      end
    join
    checks++; if (lat != 155) begin errors++; $display("FAIL single_latency: got %0d exp 155", lat); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL single_data: got %h exp 55", rx_data); end
    checks++; if (rx_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", rx_count); end
    do_pop(d);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b exp 0", rx_valid); end
    checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL single_pop_count: got %0d exp 0", rx_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      send_frame(pat[i], 1'b1);
      exp_q.push_back(pat[i]);
    end
    checks++; if (rx_count !== 5'd4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", rx_count); end
    while (exp_q.size() > 0) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin
        errors++; $display("FAIL b2b_order: got v=%b d=%h exp v=1 d=%h", rx_valid, rx_data, exp_q[0]);
      end
      do_pop(d);
      void'(exp_q.pop_front());
    end
    checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL b2b_drained: got %0d exp 0", rx_count); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b1);
      if (exp_q.size() < 16) exp_q.push_back(8'(i));
      else exp_ov = 1'b1;
    end
    checks++; if (rx_count !== 5'd16) begin errors++; $display("FAIL ovr_count: got %0d exp 16", rx_count); end
    checks++; if (overrun !== exp_ov) begin errors++; $display("FAIL ovr_flag: got %b exp %b", overrun, exp_ov); end
    while (exp_q.size() > 0) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin
        errors++; $display("FAIL ovr_order: got v=%b d=%h exp v=1 d=%h", rx_valid, rx_data, exp_q[0]);
      end
      do_pop(d);
      void'(exp_q.pop_front());
    end
    pulse_clear();
    exp_ov = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] nb, popped, d;
    for (int i = 0; i < 16; i++) begin
      nb = 8'($urandom);
      send_frame(nb, 1'b1);
      exp_q.push_back(nb);
    end
    nb = 8'($urandom);
    popped = 8'h00;
    fork
      send_frame(nb, 1'b1);
      begin
        wait_cycles(154);
        popped = rx_data;
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
      end
    join
    checks++; if (popped !== exp_q[0]) begin errors++; $display("FAIL fullpop_head: got %h exp %h", popped, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(nb);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_overrun: got %b exp 0", overrun); end
    checks++; if (rx_count !== 5'd16) begin errors++; $display("FAIL fullpop_count: got %0d exp 16", rx_count); end
    while (exp_q.size() > 0) begin
      checks++; if (rx_data !== exp_q[0]) begin
        errors++; $display("FAIL fullpop_order: got %h exp %h", rx_data, exp_q[0]);
      end
      do_pop(d);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h41, 1'b0);
    wait_cycles(4);
    checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL ferr_nopush: got %0d exp 0", rx_count); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b exp 1", frame_err); end
    pulse_clear();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b exp 0", frame_err); end
    fork
      send_frame(8'hC3, 1'b0);
      begin
        wait_cycles(154);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_pre: got %b exp 0", frame_err); end
        clear_err = 1'b1;
        wait_cycles(1);
        clear_err = 1'b0;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set_wins: got %b exp 1", frame_err); end
      end
    join
    wait_cycles(4);
    pulse_clear();
  endtask

  task automatic test_break();
    logic [7:0] d;
    rxd = 1'b0;
    wait_cycles(12 * CPB);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_set: got %b exp 1", frame_err); end
    pulse_clear();
    wait_cycles(28 * CPB);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL break_once: got %b exp 0", frame_err); end
    checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL break_nopush: got %0d exp 0", rx_count); end
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    send_frame(8'h42, 1'b1);
    checks++; if (rx_count !== 5'd1 || rx_data !== 8'h42) begin
      errors++; $display("FAIL break_after: got cnt=%0d d=%h exp cnt=1 d=42", rx_count, rx_data);
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL break_after_flag: got %b exp 0", frame_err); end
    do_pop(d);
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    rxd = 1'b0;
    wait_cycles(5);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    checks++; if (rx_count !== 5'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL glitch_quiet: got cnt=%0d fe=%b ov=%b exp 0 0 0", rx_count, frame_err, overrun);
    end
    send_frame(8'h7E, 1'b1);
    checks++; if (rx_count !== 5'd1 || rx_data !== 8'h7E) begin
      errors++; $display("FAIL glitch_after: got cnt=%0d d=%h exp cnt=1 d=7e", rx_count, rx_data);
    end
    do_pop(d);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, d;
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    send_frame(8'h0F, 1'b0);
    wait_cycles(2);
    checks++; if (rx_count !== 5'd3 || frame_err !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got cnt=%0d fe=%b exp cnt=3 fe=1", rx_count, frame_err);
    end
    b = 8'($urandom);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin rxd = b[i]; wait_cycles(CPB); end
    rxd = b[3];
    wait_cycles(CPB / 2);
    reset = 1'b1;
    rxd = 1'b1;
    wait_cycles(1);
    checks++; if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_fifo: got cnt=%0d v=%b exp 0 0", rx_count, rx_valid);
    end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got fe=%b ov=%b exp 0 0", frame_err, overrun);
    end
    reset = 1'b0;
    exp_q.delete();
    wait_cycles(2 * CPB);
    send_frame(8'h99, 1'b1);
    checks++; if (rx_count !== 5'd1 || rx_data !== 8'h99 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: got cnt=%0d d=%h fe=%b exp 1 99 0", rx_count, rx_data, frame_err);
    end
    do_pop(d);
  endtask

  task automatic test_random();
    logic [7:0] b, d;
    logic good;
    int npop;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    for (int f = 0; f < 30; f++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(b, good);
      if (!good) exp_fe = 1'b1;
      else if (exp_q.size() < 16) exp_q.push_back(b);
      else exp_ov = 1'b1;
      wait_cycles($urandom_range(2, 20));
      checks++; if (rx_count !== 5'(exp_q.size()) || frame_err !== exp_fe || overrun !== exp_ov) begin
        errors++; $display("FAIL rand_state: got cnt=%0d fe=%b ov=%b exp cnt=%0d fe=%b ov=%b",
                           rx_count, frame_err, overrun, exp_q.size(), exp_fe, exp_ov);
      end
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        if (exp_q.size() > 0) begin
          checks++; if (rx_data !== exp_q[0]) begin
            errors++; $display("FAIL rand_data: got %h exp %h", rx_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        do_pop(d);
      end
      checks++; if (rx_count !== 5'(exp_q.size())) begin
        errors++; $display("FAIL rand_count_after_pop: got %0d exp %0d", rx_count, exp_q.size());
      end
    end
    while (exp_q.size() > 0) begin
      checks++; if (rx_data !== exp_q[0]) begin errors++; $display("FAIL rand_drain: got %h exp %h", rx_data, exp_q[0]); end
      do_pop(d);
      void'(exp_q.pop_front());
    end
    pulse_clear();
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL rand_final: got fe=%b ov=%b v=%b exp 0 0 0", frame_err, overrun, rx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_full_with_pop();
    test_frame_err();
    test_break();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
